// File: rtl/cal_pkg.sv
// cal_pkg: shared state, key-code and op-code definitions for the calculator controller.
package cal_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER_A = 3'd1,
        OP      = 3'd2,
        ENTER_B = 3'd3,
        CALC    = 3'd4,
        RESULT  = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Operator keys are contiguous, so the op code is the offset from KEY_ADD.
    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        return 2'(k - KEY_ADD);
    endfunction

endpackage

// File: rtl/cal_timeout_cnt.sv
// cal_timeout_cnt: load/enable cycle counter that flags expiry after TIMEOUT counted cycles.
module cal_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = cnt == TO_W'(TIMEOUT - 1);

endmodule

// File: rtl/cal_ctrl_fsm.sv
// cal_ctrl_fsm: decodes keypad events into operand/operator/ALU strobes and supervises the ALU handshake.
module cal_ctrl_fsm
    import cal_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(DIGITS + 1),
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             calc_done,
    input  logic             calc_err,
    output logic [2:0]       state,
    output logic             sel_B,
    output logic             digit_load,
    output logic             digit_shift,
    output logic [3:0]       digit_val,
    output logic             op_load,
    output logic [1:0]       op_code,
    output logic             calc_en,
    output logic             res_to_A,
    output logic             clr_all,
    output logic             err,
    output logic [CNT_W-1:0] digit_cnt
);

    state_t           state_r, state_n;
    logic             pend, pend_n;
    logic [1:0]       pend_op, pend_op_n;
    logic             sel_b_n, load_n, shift_n, opl_n, calc_n, res_n, clr_n;
    logic [3:0]       dval_n;
    logic [1:0]       opc_n;
    logic [CNT_W-1:0] cnt_n;
    logic             dig, opk, eq, clr, room, expired;

    assign dig  = key_valid && key_code < KEY_ADD;
    assign opk  = key_valid && key_code >= KEY_ADD && key_code <= KEY_DIV;
    assign eq   = key_valid && key_code == KEY_EQ;
    assign clr  = key_valid && key_code == KEY_CLR;
    assign room = digit_cnt < CNT_W'(DIGITS);

    cal_timeout_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_r != CALC),
        .en      (1'b1),
        .expired (expired)
    );

    always_comb begin
        state_n   = state_r;
        pend_n    = pend;
        pend_op_n = pend_op;
        sel_b_n   = sel_B;
        dval_n    = digit_val;
        opc_n     = op_code;
        cnt_n     = digit_cnt;
        load_n    = 1'b0;
        shift_n   = 1'b0;
        opl_n     = 1'b0;
        calc_n    = 1'b0;
        res_n     = 1'b0;
        clr_n     = 1'b0;
        if (clr) begin
            clr_n   = 1'b1;
            cnt_n   = '0;
            pend_n  = 1'b0;
            sel_b_n = 1'b0;
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE, RESULT: begin
                    if (dig) begin
                        load_n  = 1'b1;
                        sel_b_n = 1'b0;
                        dval_n  = key_code;
                        cnt_n   = CNT_W'(1);
                        state_n = ENTER_A;
                    end else if (opk) begin
                        opl_n   = 1'b1;
                        opc_n   = key_to_op(key_code);
                        state_n = OP;
                    end else if (eq && state_r == RESULT) begin
                        calc_n  = 1'b1;
                        state_n = CALC;
                    end
                end
                ENTER_A, ENTER_B: begin
                    if (dig) begin
                        shift_n = room;
                        dval_n  = room ? key_code : digit_val;
                        cnt_n   = room ? digit_cnt + 1'b1 : digit_cnt;
                    end else if (opk && state_r == ENTER_A) begin
                        opl_n   = 1'b1;
                        opc_n   = key_to_op(key_code);
                        cnt_n   = '0;
                        state_n = OP;
                    end else if ((opk || eq) && state_r == ENTER_B) begin
                        // Operator here both launches the pending calc and queues itself for the chain.
                        calc_n    = 1'b1;
                        pend_n    = opk;
                        pend_op_n = opk ? key_to_op(key_code) : pend_op;
                        state_n   = CALC;
                    end
                end
                OP: begin
                    if (dig) begin
                        load_n  = 1'b1;
                        sel_b_n = 1'b1;
                        dval_n  = key_code;
                        cnt_n   = CNT_W'(1);
                        state_n = ENTER_B;
                    end else if (opk) begin
                        opl_n = 1'b1;
                        opc_n = key_to_op(key_code);
                    end
                end
                CALC: begin
                    if (calc_done && calc_err) begin
                        state_n = ERROR;
                    end else if (calc_done) begin
                        res_n   = 1'b1;
                        opl_n   = pend;
                        opc_n   = pend ? pend_op : op_code;
                        cnt_n   = pend ? '0 : digit_cnt;
                        pend_n  = 1'b0;
                        state_n = pend ? OP : RESULT;
                    end else if (expired) begin
                        state_n = ERROR;
                    end
                end
                ERROR: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pend        <= 1'b0;
            pend_op     <= OP_ADD;
            sel_B       <= 1'b0;
            digit_load  <= 1'b0;
            digit_shift <= 1'b0;
            digit_val   <= '0;
            op_load     <= 1'b0;
            op_code     <= OP_ADD;
            calc_en     <= 1'b0;
            res_to_A    <= 1'b0;
            clr_all     <= 1'b0;
            err         <= 1'b0;
            digit_cnt   <= '0;
        end else begin
            state_r     <= state_n;
            pend        <= pend_n;
            pend_op     <= pend_op_n;
            sel_B       <= sel_b_n;
            digit_load  <= load_n;
            digit_shift <= shift_n;
            digit_val   <= dval_n;
            op_load     <= opl_n;
            op_code     <= opc_n;
            calc_en     <= calc_n;
            res_to_A    <= res_n;
            clr_all     <= clr_n;
            err         <= state_n == ERROR;
            digit_cnt   <= cnt_n;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_cal_ctrl_fsm.sv
// tb_cal_ctrl_fsm: directed-vector bench for cal_ctrl_fsm with hand-computed expectations.
module tb_cal_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       calc_done = 1'b0;
    logic       calc_err = 1'b0;
    logic [2:0] state;
    logic       sel_B, digit_load, digit_shift, op_load, calc_en, res_to_A, clr_all, err;
    logic [3:0] digit_val;
    logic [1:0] op_code;
    logic [1:0] digit_cnt;
    logic [5:0] stb;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    cal_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .calc_done   (calc_done),
        .calc_err    (calc_err),
        .state       (state),
        .sel_B       (sel_B),
        .digit_load  (digit_load),
        .digit_shift (digit_shift),
        .digit_val   (digit_val),
        .op_load     (op_load),
        .op_code     (op_code),
        .calc_en     (calc_en),
        .res_to_A    (res_to_A),
        .clr_all     (clr_all),
        .err         (err),
        .digit_cnt   (digit_cnt)
    );

    // strobe order: load, shift, op_load, calc_en, res_to_A, clr_all
    assign stb = {digit_load, digit_shift, op_load, calc_en, res_to_A, clr_all};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic e);
        @(negedge clk);
        calc_done = 1'b1;
        calc_err  = e;
        @(negedge clk);
        calc_done = 1'b0;
        calc_err  = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_stb", stb, 0);
        check("rst_misc", {sel_B, err, digit_cnt, digit_val, op_code}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        key_code = 4'd5;
        @(negedge clk);
        check("invalid_key", state, 0);
        press(4'd14);
        check("eq_idle", {state, stb}, 0);

        press(4'd1);
        check("a1_stb", stb, 6'b100000);
        check("a1_regs", {state, sel_B, digit_cnt, digit_val}, {3'd1, 1'b0, 2'd1, 4'd1});
        press(4'd2);
        check("a2_stb", stb, 6'b010000);
        check("a2_regs", {digit_cnt, digit_val}, {2'd2, 4'd2});
        press(4'd10);
        check("add_stb", stb, 6'b001000);
        check("add_regs", {state, op_code, digit_cnt}, {3'd2, 2'd0, 2'd0});
        press(4'd3);
        check("b3_stb", stb, 6'b100000);
        check("b3_regs", {state, sel_B, digit_cnt, digit_val}, {3'd3, 1'b1, 2'd1, 4'd3});
        press(4'd14);
        check("eq_stb", stb, 6'b000100);
        check("eq_state", state, 4);
        repeat (4) @(negedge clk);
        check("calc_wait", {state, stb}, {3'd4, 6'b0});
        done_pulse(1'b0);
        check("res_stb", stb, 6'b000010);
        check("res_state", state, 5);
        @(negedge clk);
        check("pulse_width", stb, 0);

        press(4'd15);
        check("clr_stb", stb, 6'b000001);
        press(4'd9);
        press(4'd9);
        press(4'd9);
        check("drop_stb", stb, 0);
        check("drop_regs", {state, digit_cnt, digit_val}, {3'd1, 2'd2, 4'd9});

        press(4'd15);
        press(4'd4);
        press(4'd12);
        check("mul_op", op_code, 2);
        press(4'd5);
        press(4'd11);
        check("chain_stb", stb, 6'b000100);
        check("chain_state", {state, op_code}, {3'd4, 2'd2});
        done_pulse(1'b0);
        check("chain_done_stb", stb, 6'b001010);
        check("chain_done_regs", {state, op_code, digit_cnt}, {3'd2, 2'd1, 2'd0});
        press(4'd6);
        press(4'd14);
        done_pulse(1'b0);
        check("res2_state", state, 5);
        press(4'd14);
        check("repeat_stb", stb, 6'b000100);
        check("repeat_state", state, 4);
        done_pulse(1'b1);
        check("calc_err_stb", stb, 0);
        check("calc_err_regs", {state, err}, {3'd6, 1'b1});
        press(4'd7);
        check("err_digit", {state, err, stb}, {3'd6, 1'b1, 6'b0});
        press(4'd15);
        check("err_clr", {state, err, stb}, {3'd0, 1'b0, 6'b000001});

        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd14);
        repeat (63) @(negedge clk);
        check("to_63", {state, err}, {3'd4, 1'b0});
        @(negedge clk);
        check("to_64", {state, err}, {3'd6, 1'b1});
        press(4'd15);

        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd14);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd15;
        calc_done = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        calc_done = 1'b0;
        check("clr_vs_done", {state, stb}, {3'd0, 6'b000001});

        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd14);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {state, stb, err, sel_B, digit_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_pulse(1'b0);
        check("late_done", {state, stb}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cal_ctrl_fsm.md
Name: cal_ctrl_fsm

Overview:
- Parametrised control FSM for the keypad calculator; successor to the 3-state start/pause toggle controller.
- Decodes one-cycle key events into datapath strobes: operand digit entry (A/B), operator latch, calculation launch, result chaining.
- Handshakes with a multi-cycle arithmetic unit via calc_en/calc_done, with timeout and error state.
- Sits between the key-pulse generator (debounce + one-pulse) and the operand/ALU datapath.

Parameters:
DIGITS, 2, max decimal digits accepted per operand
TIMEOUT, 64, cycles to wait for calc_done before ERROR (>=2)
CNT_W, $clog2(DIGITS+1), width of digit_cnt
TO_W, $clog2(TIMEOUT+1), width of timeout counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
key_valid  in  1  one-cycle key event strobe
key_code  in  4  0-9 digit; 10 '+'; 11 '-'; 12 '*'; 13 '/'; 14 '='; 15 clear
calc_done  in  1  ALU result valid (pulse)
calc_err  in  1  ALU error (overflow/div0), qualified by calc_done
state  out  3  current state encoding
sel_B  out  1  digit/strobe target: 0 = A, 1 = B
digit_load  out  1  pulse: target <= digit_val
digit_shift  out  1  pulse: target <= target*10 + digit_val
digit_val  out  4  registered digit for load/shift
op_load  out  1  pulse: latch op_code
op_code  out  2  0 add, 1 sub, 2 mul, 3 div
calc_en  out  1  pulse: start ALU on A op B
res_to_A  out  1  pulse: A <= ALU result
clr_all  out  1  pulse: clear A, B, op in datapath
err  out  1  level, high in ERROR
digit_cnt  out  CNT_W  digits entered into current operand

Behaviour:
- All outputs registered. Reset: state=IDLE, all pulses 0, sel_B=0, digit_val=0, op_code=0, err=0, digit_cnt=0.
- Latency: a key accepted in cycle n produces its strobes in cycle n+1, each exactly one cycle wide.
- Keys with key_valid=0 are ignored. Keys not listed below for the current state are dropped; there is no queue.
- States: IDLE=0, ENTER_A=1, OP=2, ENTER_B=3, CALC=4, RESULT=5, ERROR=6. Encoding 7 recovers to IDLE.
- Clear (15) in any state: clr_all, digit_cnt=0, pending=0, go to IDLE. This includes aborting CALC.
- IDLE and RESULT:
  - digit: digit_load to A, digit_cnt=1, go to ENTER_A.
  - operator: op_load, go to OP. A holds 0 or the previous result.
  - '=' in IDLE: ignored.
  - '=' in RESULT: calc_en, go to CALC (repeat last op with same B).
- ENTER_A and ENTER_B:
  - digit with digit_cnt<DIGITS: digit_shift, digit_cnt++.
  - digit with digit_cnt==DIGITS: dropped, no strobe.
- ENTER_A: operator gives op_load, digit_cnt=0, go to OP. '=' ignored.
- OP: digit gives digit_load to B (sel_B=1), digit_cnt=1, go to ENTER_B. Operator re-issues op_load (last op wins). '=' ignored.
- ENTER_B:
  - '=': calc_en, pending=0, go to CALC.
  - operator: calc_en, pending=1, store new op, go to CALC (chaining).
- CALC:
  - Timeout counter resets on entry.
  - calc_done & calc_err: go to ERROR.
  - calc_done & !calc_err: res_to_A. If pending, op_load of the stored op, digit_cnt=0, go to OP. Otherwise go to RESULT.
  - Counter reaching TIMEOUT without calc_done: go to ERROR.
  - Non-clear keys are ignored.
  - calc_done and clear in the same cycle: clear wins.
- ERROR: err=1; only clear exits.
- rst_n assertion mid-CALC aborts immediately. A late calc_done arriving in IDLE is ignored.

Decomposition:
- Package cal_pkg: state enum, key-code constants (KEY_ADD..KEY_CLR), op-code constants, key-to-op function.
- Sub-module cal_timeout_cnt: load/enable counter with an expiry flag.

Test Plan:
- Reset, keys 1,2,'+',3,'=', calc_done at CALC+5 -> load A(1), shift(2), op_load op=0, load B(3), calc_en, res_to_A, state=RESULT.
- DIGITS=2; keys 9,9,9 -> third digit dropped, digit_cnt stays 2, no strobe.
- Chaining: 4,'*',5,'-' -> calc_en; on calc_done: res_to_A then op_load op=1, state=OP, digit_cnt=0.
- '=' in RESULT -> calc_en again. calc_done with calc_err=1 -> ERROR, err=1, digit keys ignored. Clear -> IDLE, clr_all.
- No calc_done for TIMEOUT=64 cycles -> ERROR at cycle 64. Clear and calc_done in the same cycle -> IDLE, no res_to_A.
- rst_n low mid-CALC -> all outputs at reset values asynchronously. Later calc_done -> no strobe.
